// File: rtl/dram_port_arbiter.sv
// Single-port data RAM arbiter between the Wishbone slave port and the core data port.
// One grant per cycle; the read response is routed back to whichever side owned the access.
module dram_port_arbiter #(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] WB_BASE = 32'h3000_1000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [ADDR_W+1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              ram_csb_o,
  output logic              ram_web_o,
  output logic [3:0]        ram_wmask_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  input  logic [31:0]       ram_dout_i
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CORE = 2'd1, OWN_WB = 2'd2} owner_t;

  owner_t r_owner, w_owner_nxt;
  logic   r_lcw_core, w_lcw_core_nxt;
  logic   w_wb_hit, w_wb_elig, w_core_elig, w_conflict, w_gnt_wb, w_gnt_core;
  logic   w_unused;

  assign w_unused = ^{wbs_adr_i[1:0], core_addr_i[1:0]};

  assign wbs_ack_o     = (r_owner == OWN_WB);
  assign core_rvalid_o = (r_owner == OWN_CORE);
  assign wbs_dat_o     = wbs_ack_o     ? ram_dout_i : 32'h0;
  assign core_rdata_o  = core_rvalid_o ? ram_dout_i : 32'h0;

  // A strobe still held during its ack cycle must not be taken as a new access.
  assign w_wb_hit    = wbs_cyc_i & wbs_stb_i &
                       (wbs_adr_i[31:ADDR_W+2] == WB_BASE[31:ADDR_W+2]);
  assign w_wb_elig   = rstn_i & w_wb_hit & ~wbs_ack_o;
  assign w_core_elig = rstn_i & core_req_i;
  assign w_conflict  = w_wb_elig & w_core_elig;

  // On conflict, the side that lost the previous conflict wins.
  assign w_gnt_wb   = w_wb_elig   & (~w_core_elig | r_lcw_core);
  assign w_gnt_core = w_core_elig & (~w_wb_elig   | ~r_lcw_core);
  assign core_gnt_o = w_gnt_core;

  always_comb begin
    w_owner_nxt    = OWN_NONE;
    w_lcw_core_nxt = r_lcw_core;
    ram_csb_o      = 1'b1;
    ram_web_o      = 1'b1;
    ram_wmask_o    = 4'h0;
    ram_addr_o     = '0;
    ram_din_o      = 32'h0;
    if (w_gnt_core) begin
      w_owner_nxt = OWN_CORE;
      ram_csb_o   = 1'b0;
      ram_web_o   = ~core_we_i;
      ram_wmask_o = core_we_i ? core_be_i : 4'h0;
      ram_addr_o  = core_addr_i[ADDR_W+1:2];
      ram_din_o   = core_wdata_i;
    end else if (w_gnt_wb) begin
      w_owner_nxt = OWN_WB;
      ram_csb_o   = 1'b0;
      ram_web_o   = ~wbs_we_i;
      ram_wmask_o = wbs_we_i ? wbs_sel_i : 4'h0;
      ram_addr_o  = wbs_adr_i[ADDR_W+1:2];
      ram_din_o   = wbs_dat_i;
    end
    if (w_conflict) w_lcw_core_nxt = w_gnt_core;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_owner    <= OWN_NONE;
      r_lcw_core <= 1'b1;
    end else begin
      r_owner    <= w_owner_nxt;
      r_lcw_core <= w_lcw_core_nxt;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: behavioural SRAM, directed vectors/sequences, randomized traffic vs a reference model.
module tb_dram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [9:0]  core_addr_i;
  logic [31:0] core_wdata_i;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ram_csb_o, ram_web_o;
  logic [3:0]  ram_wmask_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_din_o;
  logic [31:0] ram_dout;

  dram_port_arbiter #(.ADDR_W(8), .WB_BASE(32'h3000_1000)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .ram_csb_o(ram_csb_o), .ram_web_o(ram_web_o), .ram_wmask_o(ram_wmask_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout)
  );

  // Single-port SRAM with 1-cycle read latency
  bit [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (!ram_csb_o) begin
      if (!ram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
      end else begin
        ram_dout <= ram_mem[ram_addr_o];
      end
    end
  end

  typedef struct {
    bit rstn; bit cyc; bit stb; bit wwe; bit [3:0] sel; bit [31:0] adr; bit [31:0] wdat;
    bit creq; bit cwe; bit [3:0] cbe; bit [9:0] caddr; bit [31:0] cwdat;
  } in_t;
  typedef struct { bit gnt; bit csb; bit web; bit [3:0] m; bit [7:0] a; bit [31:0] d; } obs_t;
  typedef struct {
    in_t v; bit gnt; bit csb; bit web; bit [3:0] m; bit [7:0] a; bit [31:0] d; bit ack; bit rv;
  } vec_t;

  int checks = 0, failures = 0;

  // Reference model: who owns the pending response, what it should return, and conflict history
  int        m_owner;      // 0 none, 1 core, 2 wb
  bit        m_rd;
  bit [31:0] m_data;
  bit        m_core_last;  // core won the most recent conflict
  bit [31:0] shadow [256];

  localparam bit [31:0] BASE = 32'h3000_1000;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", n, a, e, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: 0};
    v.rstn = 1'b1;
    return v;
  endfunction

  function automatic in_t wbv(bit we, bit [3:0] sel, bit [31:0] adr, bit [31:0] dat);
    in_t v;
    v = idle();
    v.cyc = 1'b1; v.stb = 1'b1; v.wwe = we; v.sel = sel; v.adr = adr; v.wdat = dat;
    return v;
  endfunction

  function automatic in_t withcore(in_t vi, bit we, bit [3:0] be, bit [9:0] a, bit [31:0] d);
    in_t v;
    v = vi;
    v.creq = 1'b1; v.cwe = we; v.cbe = be; v.caddr = a; v.cwdat = d;
    return v;
  endfunction

  function automatic vec_t mk(in_t v, bit gnt, bit csb, bit web, bit [3:0] m, bit [7:0] a,
                              bit [31:0] d, bit ack, bit rv);
    vec_t t;
    t.v = v; t.gnt = gnt; t.csb = csb; t.web = web; t.m = m; t.a = a; t.d = d;
    t.ack = ack; t.rv = rv;
    return t;
  endfunction

  // One clock: drive at negedge, check at +1, model update at posedge, return at next negedge
  task automatic cycle(input in_t v, output obs_t o);
    bit wb_ok, core_ok, conf, we;
    int win;
    bit [3:0]  be, e_m;
    bit [7:0]  a, e_a;
    bit [31:0] d, e_d;
    bit        e_csb, e_web;
    rstn_i = v.rstn; wbs_cyc_i = v.cyc; wbs_stb_i = v.stb; wbs_we_i = v.wwe;
    wbs_sel_i = v.sel; wbs_adr_i = v.adr; wbs_dat_i = v.wdat;
    core_req_i = v.creq; core_we_i = v.cwe; core_be_i = v.cbe;
    core_addr_i = v.caddr; core_wdata_i = v.cwdat;
    if (!v.rstn) begin m_owner = 0; m_core_last = 1'b1; end
    wb_ok   = v.rstn && v.cyc && v.stb && v.adr >= BASE && v.adr < BASE + 32'd1024 && m_owner != 2;
    core_ok = v.rstn && v.creq;
    conf    = wb_ok && core_ok;
    if (conf) win = m_core_last ? 2 : 1;
    else      win = core_ok ? 1 : (wb_ok ? 2 : 0);
    we = 1'b0; be = 4'h0; a = 8'h0; d = 32'h0;
    if (win == 1) begin
      we = v.cwe; be = v.cbe; a = 8'(v.caddr >> 2); d = v.cwdat;
    end else if (win == 2) begin
      we = v.wwe; be = v.sel; a = 8'((v.adr - BASE) >> 2); d = v.wdat;
    end
    e_csb = (win == 0); e_web = (win == 0) || !we;
    e_m = (win != 0 && we) ? be : 4'h0; e_a = a; e_d = d;
    #1;
    o.gnt = core_gnt_o; o.csb = ram_csb_o; o.web = ram_web_o;
    o.m = ram_wmask_o; o.a = ram_addr_o; o.d = ram_din_o;
    chk("gnt", 32'(core_gnt_o), 32'(win == 1));
    chk("ram_csb", 32'(ram_csb_o), 32'(e_csb));
    chk("ram_web", 32'(ram_web_o), 32'(e_web));
    chk("ram_wmask", 32'(ram_wmask_o), 32'(e_m));
    chk("ram_addr", 32'(ram_addr_o), 32'(e_a));
    chk("ram_din", ram_din_o, e_d);
    chk("wb_ack", 32'(wbs_ack_o), 32'(m_owner == 2));
    chk("core_rvalid", 32'(core_rvalid_o), 32'(m_owner == 1));
    if (m_owner == 1 && m_rd) chk("core_rdata", core_rdata_o, m_data);
    else if (m_owner != 1)    chk("core_rdata_idle", core_rdata_o, 32'h0);
    if (m_owner == 2 && m_rd) chk("wb_dat", wbs_dat_o, m_data);
    else if (m_owner != 2)    chk("wb_dat_idle", wbs_dat_o, 32'h0);
    @(posedge clk);
    if (v.rstn) begin
      if (conf) m_core_last = (win == 1);
      m_owner = win;
      if (win != 0) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
          m_rd = 1'b0;
        end else begin
          m_rd = 1'b1; m_data = shadow[a];
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    obs_t o;
    in_t  v, rst_v;
    vec_t tbl [$];
    bit   exp_g [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit [31:0] snap [256];
    int   diffs;

    m_owner = 0; m_rd = 1'b0; m_data = 32'h0; m_core_last = 1'b1;
    rst_v = idle(); rst_v.rstn = 1'b0;
    rstn_i = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; core_req_i = 0; core_we_i = 0; core_be_i = 0;
    core_addr_i = 0; core_wdata_i = 0;

    tbl.push_back(mk(idle(), 0, 1, 1, 4'h0, 8'h00, 32'h0, 0, 0));
    tbl.push_back(mk(withcore(idle(), 0, 4'hF, 10'h03C, 32'h12345678), 1, 0, 1, 4'h0, 8'h0F, 32'h12345678, 0, 1));
    tbl.push_back(mk(withcore(idle(), 1, 4'h5, 10'h3FC, 32'hA5A5A5A5), 1, 0, 0, 4'h5, 8'hFF, 32'hA5A5A5A5, 0, 1));
    tbl.push_back(mk(wbv(0, 4'hF, 32'h300010F0, 32'h0), 0, 0, 1, 4'h0, 8'h3C, 32'h0, 1, 0));
    tbl.push_back(mk(wbv(1, 4'h3, 32'h300013FC, 32'hCAFEF00D), 0, 0, 0, 4'h3, 8'hFF, 32'hCAFEF00D, 1, 0));
    tbl.push_back(mk(wbv(0, 4'hF, 32'h30001400, 32'h0), 0, 1, 1, 4'h0, 8'h00, 32'h0, 0, 0));
    tbl.push_back(mk(wbv(1, 4'hF, 32'h30000FFC, 32'h5), 0, 1, 1, 4'h0, 8'h00, 32'h0, 0, 0));
    v = wbv(0, 4'hF, 32'h30001000, 32'h0); v.cyc = 1'b0;
    tbl.push_back(mk(v, 0, 1, 1, 4'h0, 8'h00, 32'h0, 0, 0));
    tbl.push_back(mk(withcore(wbv(1, 4'hF, 32'h30001004, 32'h11111111), 0, 4'hF, 10'h008, 32'h22222222),
                     0, 0, 0, 4'hF, 8'h01, 32'h11111111, 1, 0));
    tbl.push_back(mk(withcore(wbv(0, 4'hF, 32'h30001020, 32'h0), 1, 4'hC, 10'h00C, 32'h33333333),
                     0, 0, 1, 4'h0, 8'h08, 32'h0, 1, 0));
    tbl.push_back(mk(withcore(wbv(0, 4'hF, 32'h40001000, 32'h0), 0, 4'hF, 10'h010, 32'h44),
                     1, 0, 1, 4'h0, 8'h04, 32'h44, 0, 1));

    @(negedge clk);
    // Reset with both requesters active
    v = withcore(wbv(0, 4'hF, 32'h30001010, 32'h0), 0, 4'hF, 10'h010, 32'h0); v.rstn = 1'b0;
    cycle(v, o);
    chk("rst_csb", 32'(o.csb), 32'd1);
    chk("rst_gnt", 32'(o.gnt), 32'd0);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_rvalid", 32'(core_rvalid_o), 32'd0);

    // WB write then read back
    cycle(wbv(1, 4'hF, 32'h30001010, 32'hDEADBEEF), o);
    chk("wb_wr_ack", 32'(wbs_ack_o), 32'd1);
    cycle(idle(), o);
    cycle(wbv(0, 4'hF, 32'h30001010, 32'h0), o);
    chk("wb_rd_ack", 32'(wbs_ack_o), 32'd1);
    chk("wb_rd_data", wbs_dat_o, 32'hDEADBEEF);
    cycle(idle(), o);

    // Byte masks from both sides
    cycle(wbv(1, 4'b0010, 32'h30001010, 32'h0000AB00), o);
    cycle(idle(), o);
    cycle(wbv(0, 4'hF, 32'h30001010, 32'h0), o);
    chk("wb_mask_data", wbs_dat_o, 32'hDEADABEF);
    cycle(withcore(idle(), 1, 4'b1000, 10'h010, 32'h11000000), o);
    chk("core_wr_rvalid", 32'(core_rvalid_o), 32'd1);
    cycle(withcore(idle(), 0, 4'hF, 10'h010, 32'h0), o);
    chk("core_mask_data", core_rdata_o, 32'h11ADABEF);
    cycle(idle(), o);

    // Conflict after reset: WB first, then core in the ack cycle, then round-robin
    cycle(rst_v, o);
    v = withcore(wbv(0, 4'hF, 32'h30001014, 32'h0), 0, 4'hF, 10'h014, 32'h0);
    for (int k = 0; k < 6; k++) begin
      cycle(v, o);
      chk($sformatf("conflict_gnt%0d", k), 32'(o.gnt), 32'(exp_g[k]));
    end
    cycle(idle(), o);

    // Out-of-window WB while the core streams reads
    for (int k = 0; k < 6; k++) begin
      cycle(withcore(wbv(0, 4'hF, 32'h30002000, 32'h0), 0, 4'hF, 10'(k * 4), 32'h0), o);
      chk("oow_ram_addr", 32'(o.a), k);
      chk("oow_no_ack", 32'(wbs_ack_o), 32'd0);
      chk("oow_rvalid", 32'(core_rvalid_o), 32'd1);
    end
    cycle(idle(), o);

    // Reset in the cycle after a WB read is accepted
    cycle(wbv(0, 4'hF, 32'h30001018, 32'h0), o);
    snap = ram_mem;
    v = withcore(wbv(1, 4'hF, 32'h30001018, 32'hFFFFFFFF), 1, 4'hF, 10'h018, 32'hEEEEEEEE);
    v.rstn = 1'b0;
    cycle(v, o);
    chk("midrst_ack", 32'(wbs_ack_o), 32'd0);
    chk("midrst_csb", 32'(o.csb), 32'd1);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] != snap[i]) diffs++;
    chk("midrst_ram_kept", diffs, 0);
    cycle(idle(), o);

    // Directed vectors, each from a fresh reset
    foreach (tbl[i]) begin
      cycle(rst_v, o);
      cycle(tbl[i].v, o);
      chk($sformatf("vec%0d_gnt", i), 32'(o.gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_csb", i), 32'(o.csb), 32'(tbl[i].csb));
      chk($sformatf("vec%0d_web", i), 32'(o.web), 32'(tbl[i].web));
      chk($sformatf("vec%0d_wmask", i), 32'(o.m), 32'(tbl[i].m));
      chk($sformatf("vec%0d_addr", i), 32'(o.a), 32'(tbl[i].a));
      chk($sformatf("vec%0d_din", i), o.d, tbl[i].d);
      chk($sformatf("vec%0d_ack", i), 32'(wbs_ack_o), 32'(tbl[i].ack));
      chk($sformatf("vec%0d_rvalid", i), 32'(core_rvalid_o), 32'(tbl[i].rv));
    end
    cycle(idle(), o);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.rstn  = ($urandom_range(0, 199) != 0);
      v.cyc   = ($urandom_range(0, 9) != 0);
      v.stb   = ($urandom_range(0, 3) != 0);
      v.wwe   = 1'($urandom_range(0, 1));
      v.sel   = 4'($urandom);
      v.wdat  = $urandom;
      case ($urandom_range(0, 9))
        0:       v.adr = $urandom;
        1:       v.adr = 32'h30001400 + 32'($urandom_range(0, 15) << 2);
        default: v.adr = BASE + 32'($urandom_range(0, 63));
      endcase
      v.creq  = ($urandom_range(0, 2) != 0);
      v.cwe   = 1'($urandom_range(0, 1));
      v.cbe   = 4'($urandom);
      v.caddr = 10'($urandom_range(0, 63));
      v.cwdat = $urandom;
      cycle(v, o);
    end
    cycle(idle(), o);
    cycle(idle(), o);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] != shadow[i]) diffs++;
    chk("ram_vs_model", diffs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
